apb_irq_stim_engine: RTL and testbench
======================================

Name: apb_irq_stim_engine

Overview:
Synthesizable, parametrised stimulus engine for APB slaves with interrupt outputs, such as the interrupt controller. It accepts a stream of commands over a valid/ready port: APB write, APB read-with-compare, IRQ pulse, or idle wait. It drives a single APB master port and an IRQ trigger vector, and monitors the slave's interrupt output. It adds PREADY wait-state handling, access timeout, PSLVERR capture, read checking, configurable IRQ count and pulse width, and interrupt edge counting.

Parameters:
ADDR_W, 32, APB address width
DATA_W, 32, APB data width
NUM_IRQ, 4, number of IRQ trigger lines (1..32, must be <= DATA_W)
PULSE_W, 1, IRQ pulse length in cycles (>=1)
TIMEOUT_CYC, 16, max ACCESS cycles waiting for pready (>=1)
CNT_W, 8, width of event/mismatch counters

Ports:
pclk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
enable_i  in  1  engine enable; 0 freezes FSM and all counters
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_op_i  in  2  00 write, 01 read, 10 irq pulse, 11 wait
cmd_addr_i  in  ADDR_W  APB address
cmd_data_i  in  DATA_W  write data / expected read data / irq vector [NUM_IRQ-1:0] / wait count [15:0]
cmd_mask_i  in  DATA_W  read compare mask (1 = bit checked)
psel_o  out  1  APB select
penable_o  out  1  APB enable
pwrite_o  out  1  APB direction
paddr_o  out  ADDR_W  APB address
pwdata_o  out  DATA_W  APB write data
prdata_i  in  DATA_W  APB read data
pready_i  in  1  APB ready
pslverr_i  in  1  APB slave error
irq_trigger_o  out  NUM_IRQ  IRQ request pulses
interrupt_i  in  1  slave interrupt output, synchronous to pclk
rd_valid_o  out  1  one-cycle strobe, read completed
rd_data_o  out  DATA_W  captured prdata
clr_stat_i  in  1  synchronous clear of counters and sticky errors
irq_count_o  out  CNT_W  rising edges seen on interrupt_i, saturating
mismatch_cnt_o  out  CNT_W  read compare failures, saturating
err_timeout_o  out  1  sticky, access timed out
err_slverr_o  out  1  sticky, pslverr seen on completion
busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset (asynchronous, also mid-operation): every output goes to 0, except cmd_ready_o, which is 1 when enable_i=1. FSM returns to IDLE. Counters, sticky errors and the interrupt_i edge register clear.
- FSM states: IDLE, SETUP, ACCESS, PULSE, WAIT. enable_i=0 holds the current state and all registered outputs. cmd_ready_o=0 while enable_i=0.
- IDLE: cmd_ready_o=enable_i. On accept, latch op/addr/data/mask.
  - op 00/01 -> SETUP.
  - op 10 -> PULSE.
  - op 11 -> WAIT.
- SETUP (1 cycle): psel_o=1, penable_o=0; paddr_o/pwrite_o/pwdata_o valid. pwdata_o=0 for reads. Next state ACCESS.
- ACCESS: psel_o=1, penable_o=1, address/data held stable.
  - pready_i=1 completes the access: next cycle psel_o=penable_o=0, FSM goes to IDLE.
  - Back-to-back transfers always have one IDLE cycle between them. A zero-wait write takes 3 cycles from accept to cmd_ready_o=1.
- Timeout: a counter increments each ACCESS cycle with pready_i=0. After TIMEOUT_CYC such cycles, psel_o/penable_o drop, err_timeout_o sets, FSM goes to IDLE, and no rd_valid_o is issued.
- Completion with pslverr_i=1 sets err_slverr_o. The read data is still reported.
- Read completion: in the cycle after completion, rd_valid_o=1 for 1 cycle and rd_data_o=prdata_i as sampled. rd_data_o holds until the next read.
  - Mismatch if (prdata_i & mask) != (expected & mask). A mismatch increments mismatch_cnt_o, which saturates at 2^CNT_W-1.
- PULSE: irq_trigger_o=cmd_data[NUM_IRQ-1:0] for exactly PULSE_W cycles, then 0 and FSM goes to IDLE. An all-zero vector still takes PULSE_W cycles.
- WAIT: stays max(count,1) cycles (count=cmd_data[15:0]), then IDLE.
- Interrupt monitor: registers interrupt_i; a 0->1 transition increments irq_count_o (saturating). The monitor runs in any FSM state while enable_i=1.
- clr_stat_i: clears irq_count_o, mismatch_cnt_o, err_timeout_o and err_slverr_o next cycle. If it coincides with an increment or error event, the clear wins.
- busy_o=1 in every state except IDLE.

Test Plan:
- Write addr 2 data 0xF, pready_i tied 1 -> SETUP at T+1, ACCESS at T+2, psel_o=0 at T+3, cmd_ready_o=1 at T+3, no error.
- Read addr 5, pready_i low for 3 ACCESS cycles, prdata_i=0x5, expected 0x5, mask 0x7 -> rd_valid_o pulse, rd_data_o=0x5, mismatch_cnt_o=0. Repeat with expected 0x4 -> mismatch_cnt_o=1.
- IRQ pulse 4'b1010 with PULSE_W=2 -> irq_trigger_o=1010 for exactly 2 cycles, then 0000; busy_o low after.
- pready_i stuck 0, TIMEOUT_CYC=16 -> psel_o drops after 16 ACCESS cycles, err_timeout_o=1, no rd_valid_o. clr_stat_i -> err_timeout_o=0.
- Three pulses on interrupt_i -> irq_count_o=3. A 4th rising edge coincident with clr_stat_i -> irq_count_o=0.
- rst_n asserted during ACCESS -> psel_o/penable_o/irq_trigger_o=0 immediately. After release, cmd_ready_o=1 and the next write completes normally.

Source files
------------

// File: rtl/apb_irq_stim_engine_if.sv
// Command stream and APB master bundle for apb_irq_stim_engine.
//   cmd_*   : valid/ready command port (op, addr, data, mask)
//   p*      : APB master signals (engine drives psel/penable/pwrite/paddr/pwdata)
// master modport is the engine side; slave modport is the command source / APB slave side.
interface apb_irq_stim_engine_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [1:0]        cmd_op_i;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [DATA_W-1:0] cmd_data_i;
  logic [DATA_W-1:0] cmd_mask_i;
  logic              psel_o;
  logic              penable_o;
  logic              pwrite_o;
  logic [ADDR_W-1:0] paddr_o;
  logic [DATA_W-1:0] pwdata_o;
  logic [DATA_W-1:0] prdata_i;
  logic              pready_i;
  logic              pslverr_i;

  modport master (
    input  cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i, cmd_mask_i,
    input  prdata_i, pready_i, pslverr_i,
    output cmd_ready_o, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
  );

  modport slave (
    output cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i, cmd_mask_i,
    output prdata_i, pready_i, pslverr_i,
    input  cmd_ready_o, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
  );
endinterface

// File: rtl/apb_irq_stim_engine.sv
// Stimulus engine for APB slaves with an interrupt output.
// Executes one command at a time: APB write, APB read-with-compare, IRQ pulse, idle wait.
// Ports:
//   pclk, rst_n      : clock, async active-low reset
//   enable_i         : 0 freezes FSM, counters and registered outputs
//   bus (master)     : command stream + APB master
//   irq_trigger_o    : IRQ request pulses
//   interrupt_i      : slave interrupt, edge-counted into irq_count_o
//   rd_valid_o/rd_data_o : read completion strobe and captured prdata
//   clr_stat_i       : clears counters and sticky errors
//   irq_count_o, mismatch_cnt_o, err_timeout_o, err_slverr_o, busy_o : status
module apb_irq_stim_engine #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_IRQ     = 4,
  parameter int unsigned PULSE_W     = 1,
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                pclk,
  input  logic                rst_n,
  input  logic                enable_i,
  apb_irq_stim_engine_if.master bus,
  output logic [NUM_IRQ-1:0]  irq_trigger_o,
  input  logic                interrupt_i,
  output logic                rd_valid_o,
  output logic [DATA_W-1:0]   rd_data_o,
  input  logic                clr_stat_i,
  output logic [CNT_W-1:0]    irq_count_o,
  output logic [CNT_W-1:0]    mismatch_cnt_o,
  output logic                err_timeout_o,
  output logic                err_slverr_o,
  output logic                busy_o
);

  // Shared state timer: ACCESS timeout, PULSE length and WAIT length.
  localparam int unsigned TMR_W = 32;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_PULSE  = 3'd3,
    S_WAIT   = 3'd4
  } state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [1:0]          r_op;
  logic [DATA_W-1:0]   r_data;
  logic [DATA_W-1:0]   r_mask;
  logic [TMR_W-1:0]    r_tmr;
  logic                r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;
  logic [NUM_IRQ-1:0]  r_irq_trig;
  logic                r_rd_valid;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_irq_d;
  logic [CNT_W-1:0]    r_irq_cnt;
  logic [CNT_W-1:0]    r_mis_cnt;
  logic                r_err_to;
  logic                r_err_slv;

  logic                w_accept;
  logic                w_done;
  logic                w_timeout;
  logic                w_pulse_last;
  logic                w_wait_last;
  logic [15:0]         w_wait_len;
  logic                w_is_rd;
  logic                w_mismatch;
  logic                w_irq_rise;
  logic [TMR_W-1:0]    w_tmr_nxt;
  logic                w_psel_nxt;
  logic                w_penable_nxt;
  logic [NUM_IRQ-1:0]  w_irq_nxt;
  logic                w_rd_valid_nxt;

  // Event decode shared by next-state and output logic.
  assign w_accept     = enable_i && bus.cmd_valid_i && (r_state == S_IDLE);
  assign w_is_rd      = (r_op == 2'b01);
  assign w_done       = (r_state == S_ACCESS) && bus.pready_i;
  assign w_timeout    = (r_state == S_ACCESS) && !bus.pready_i &&
                        (r_tmr == TMR_W'(TIMEOUT_CYC - 1));
  assign w_pulse_last = (r_tmr == TMR_W'(PULSE_W - 1));
  assign w_wait_len   = (r_data[15:0] == 16'd0) ? 16'd1 : r_data[15:0];
  assign w_wait_last  = (r_tmr == (TMR_W'(w_wait_len) - TMR_W'(1)));
  assign w_mismatch   = (((bus.prdata_i ^ r_data) & r_mask) != '0);
  assign w_irq_rise   = interrupt_i && !r_irq_d;

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          unique case (bus.cmd_op_i)
            2'b00, 2'b01: w_state_nxt = S_SETUP;
            2'b10:        w_state_nxt = S_PULSE;
            default:      w_state_nxt = S_WAIT;
          endcase
        end
      end
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: if (bus.pready_i || w_timeout) w_state_nxt = S_IDLE;
      S_PULSE:  if (w_pulse_last) w_state_nxt = S_IDLE;
      S_WAIT:   if (w_wait_last) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, decoded from the next state.
  always_comb begin
    w_psel_nxt     = (w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS);
    w_penable_nxt  = (w_state_nxt == S_ACCESS);
    w_rd_valid_nxt = w_done && w_is_rd;
    w_irq_nxt      = '0;
    if (w_state_nxt == S_PULSE) begin
      // On the accept cycle the vector is not latched yet.
      w_irq_nxt = w_accept ? bus.cmd_data_i[NUM_IRQ-1:0] : r_data[NUM_IRQ-1:0];
    end
    // Timer restarts on every state change and idles at zero.
    w_tmr_nxt = r_tmr + TMR_W'(1);
    if ((w_state_nxt != r_state) || (r_state == S_IDLE)) begin
      w_tmr_nxt = '0;
    end
  end

  // State register plus registered outputs and status.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_data     <= '0;
      r_mask     <= '0;
      r_tmr      <= '0;
      r_psel     <= 1'b0;
      r_penable  <= 1'b0;
      r_pwrite   <= 1'b0;
      r_paddr    <= '0;
      r_pwdata   <= '0;
      r_irq_trig <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_irq_d    <= 1'b0;
      r_irq_cnt  <= '0;
      r_mis_cnt  <= '0;
      r_err_to   <= 1'b0;
      r_err_slv  <= 1'b0;
    end else if (enable_i) begin
      r_state    <= w_state_nxt;
      r_tmr      <= w_tmr_nxt;
      r_psel     <= w_psel_nxt;
      r_penable  <= w_penable_nxt;
      r_irq_trig <= w_irq_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_irq_d    <= interrupt_i;

      if (w_accept) begin
        r_op   <= bus.cmd_op_i;
        r_data <= bus.cmd_data_i;
        r_mask <= bus.cmd_mask_i;
        if (!bus.cmd_op_i[1]) begin
          r_paddr  <= bus.cmd_addr_i;
          r_pwrite <= (bus.cmd_op_i == 2'b00);
          r_pwdata <= (bus.cmd_op_i == 2'b00) ? bus.cmd_data_i : '0;
        end
      end

      if (w_done && w_is_rd) begin
        r_rd_data <= bus.prdata_i;
      end

      // Clear has priority over any same-cycle event.
      if (clr_stat_i) begin
        r_irq_cnt <= '0;
        r_mis_cnt <= '0;
        r_err_to  <= 1'b0;
        r_err_slv <= 1'b0;
      end else begin
        if (w_irq_rise && (r_irq_cnt != {CNT_W{1'b1}})) begin
          r_irq_cnt <= r_irq_cnt + CNT_W'(1);
        end
        if (w_done && w_is_rd && w_mismatch && (r_mis_cnt != {CNT_W{1'b1}})) begin
          r_mis_cnt <= r_mis_cnt + CNT_W'(1);
        end
        if (w_timeout) begin
          r_err_to <= 1'b1;
        end
        if (w_done && bus.pslverr_i) begin
          r_err_slv <= 1'b1;
        end
      end
    end
  end

  assign bus.cmd_ready_o = enable_i && (r_state == S_IDLE);
  assign bus.psel_o      = r_psel;
  assign bus.penable_o   = r_penable;
  assign bus.pwrite_o    = r_pwrite;
  assign bus.paddr_o     = r_paddr;
  assign bus.pwdata_o    = r_pwdata;
  assign irq_trigger_o   = r_irq_trig;
  assign rd_valid_o      = r_rd_valid;
  assign rd_data_o       = r_rd_data;
  assign irq_count_o     = r_irq_cnt;
  assign mismatch_cnt_o  = r_mis_cnt;
  assign err_timeout_o   = r_err_to;
  assign err_slverr_o    = r_err_slv;
  assign busy_o          = (r_state != S_IDLE);

endmodule

// File: tb/tb_apb_irq_stim_engine.sv
// Self-checking bench for apb_irq_stim_engine: reset state, a table of commands with
// hand-derived expectations, multi-cycle corner sequences, and a randomized command
// stream checked against a per-command timing/status model.
module tb_apb_irq_stim_engine;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NI = 4;
  localparam int unsigned PW = 2;
  localparam int unsigned TO = 16;
  localparam int unsigned CW = 8;

  logic          pclk = 1'b0;
  logic          rst_n;
  logic          enable_i;
  logic          interrupt_i;
  logic          clr_stat_i;
  logic [NI-1:0] irq_trigger_o;
  logic          rd_valid_o;
  logic [DW-1:0] rd_data_o;
  logic [CW-1:0] irq_count_o;
  logic [CW-1:0] mismatch_cnt_o;
  logic          err_timeout_o;
  logic          err_slverr_o;
  logic          busy_o;

  apb_irq_stim_engine_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_irq_stim_engine #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_IRQ(NI), .PULSE_W(PW), .TIMEOUT_CYC(TO), .CNT_W(CW)
  ) dut (
    .pclk(pclk), .rst_n(rst_n), .enable_i(enable_i), .bus(bus),
    .irq_trigger_o(irq_trigger_o), .interrupt_i(interrupt_i),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .clr_stat_i(clr_stat_i),
    .irq_count_o(irq_count_o), .mismatch_cnt_o(mismatch_cnt_o),
    .err_timeout_o(err_timeout_o), .err_slverr_o(err_slverr_o), .busy_o(busy_o)
  );

  always #5 pclk = ~pclk;

  // APB slave responder: pready rises after resp_wait ACCESS cycles.
  int            resp_wait  = 0;
  logic [DW-1:0] resp_rdata = '0;
  logic          resp_err   = 1'b0;
  int            acc_cyc    = 0;
  always @(posedge pclk) begin
    if (bus.psel_o && bus.penable_o) acc_cyc <= acc_cyc + 1;
    else                             acc_cyc <= 0;
  end
  assign bus.pready_i  = bus.psel_o && bus.penable_o && (acc_cyc >= resp_wait);
  assign bus.prdata_i  = resp_rdata;
  assign bus.pslverr_i = resp_err;

  int n_chk  = 0;
  int n_fail = 0;

  // Per-command observations gathered once per cycle.
  int            m_psel, m_rdv, m_trig, m_edges;
  logic [NI-1:0] m_trig_val;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_pwrite;
  bit            irq_rand = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    logic nv;
    @(posedge pclk);
    #1;
    if (irq_rand) begin
      nv = 1'($urandom_range(0, 1));
      if (nv && !interrupt_i) m_edges++;
      interrupt_i = nv;
    end
    if (bus.psel_o) m_psel++;
    if (bus.psel_o && bus.penable_o) begin
      m_addr   = bus.paddr_o;
      m_wdata  = bus.pwdata_o;
      m_pwrite = bus.pwrite_o;
    end
    if (rd_valid_o) m_rdv++;
    if (irq_trigger_o != '0) begin
      m_trig++;
      m_trig_val = irq_trigger_o;
    end
  endtask

  task automatic clear_stats();
    clr_stat_i = 1'b1;
    tick();
    clr_stat_i = 1'b0;
  endtask

  // Issue one command and return cycles from the accept edge until cmd_ready_o is back.
  task automatic run_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] mask, output int cyc);
    int g;
    bus.cmd_op_i    = op;
    bus.cmd_addr_i  = addr;
    bus.cmd_data_i  = data;
    bus.cmd_mask_i  = mask;
    bus.cmd_valid_i = 1'b1;
    g = 0;
    while (!bus.cmd_ready_o && g < 50) begin
      tick();
      g++;
    end
    m_psel = 0; m_rdv = 0; m_trig = 0; m_trig_val = '0;
    m_addr = '0; m_wdata = '0; m_pwrite = 1'b0;
    tick();
    bus.cmd_valid_i = 1'b0;
    cyc = 1;
    while (!bus.cmd_ready_o && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] mask;
    int          wt;
    logic [31:0] rdata;
    logic        slverr;
    int          e_cyc;
    int          e_psel;
    int          e_rdv;
    int          e_trig;
    logic [3:0]  e_tv;
    logic [7:0]  e_mis;
    logic        e_to;
    logic        e_slv;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [1:0]  op;
    logic [31:0] addr, data, mask, rdata;
    int  wt, exp_cyc, exp_rdv, exp_trig, mdl_mis;
    bit  err, apb, done, mdl_to, mdl_slv;

    //          op     addr         data           mask       wt    rdata        err   cyc psel rdv trig tv     mis    to    slv
    tbl[0]  = '{2'b00, 32'h2,       32'hF,         32'h0,     0,    32'h0,       1'b0, 3,  2,   0,  0,   4'h0, 8'd0, 1'b0, 1'b0};
    tbl[1]  = '{2'b01, 32'h5,       32'h5,         32'h7,     3,    32'h5,       1'b0, 6,  5,   1,  0,   4'h0, 8'd0, 1'b0, 1'b0};
    tbl[2]  = '{2'b01, 32'h5,       32'h4,         32'h7,     3,    32'h5,       1'b0, 6,  5,   1,  0,   4'h0, 8'd1, 1'b0, 1'b0};
    tbl[3]  = '{2'b01, 32'h9,       32'hF0,        32'h0F,    0,    32'hA0,      1'b0, 3,  2,   1,  0,   4'h0, 8'd0, 1'b0, 1'b0};
    tbl[4]  = '{2'b00, 32'h100,     32'hDEADBEEF,  32'h0,     1,    32'h0,       1'b1, 4,  3,   0,  0,   4'h0, 8'd0, 1'b0, 1'b1};
    tbl[5]  = '{2'b01, 32'h104,     32'h0,         32'h0,     0,    32'h1234,    1'b1, 3,  2,   1,  0,   4'h0, 8'd0, 1'b0, 1'b1};
    tbl[6]  = '{2'b10, 32'h0,       32'hA,         32'h0,     0,    32'h0,       1'b0, 3,  0,   0,  2,   4'hA, 8'd0, 1'b0, 1'b0};
    tbl[7]  = '{2'b10, 32'h0,       32'h0,         32'h0,     0,    32'h0,       1'b0, 3,  0,   0,  0,   4'h0, 8'd0, 1'b0, 1'b0};
    tbl[8]  = '{2'b11, 32'h0,       32'h0,         32'h0,     0,    32'h0,       1'b0, 2,  0,   0,  0,   4'h0, 8'd0, 1'b0, 1'b0};
    tbl[9]  = '{2'b11, 32'h0,       32'h5,         32'h0,     0,    32'h0,       1'b0, 6,  0,   0,  0,   4'h0, 8'd0, 1'b0, 1'b0};
    tbl[10] = '{2'b01, 32'h20,      32'h0,         32'h0,     1000, 32'h0,       1'b0, 18, 17,  0,  0,   4'h0, 8'd0, 1'b1, 1'b0};
    tbl[11] = '{2'b10, 32'h0,       32'hFFFFFFF5,  32'h0,     0,    32'h0,       1'b0, 3,  0,   0,  2,   4'h5, 8'd0, 1'b0, 1'b0};

    rst_n = 1'b1; enable_i = 1'b1; interrupt_i = 1'b0; clr_stat_i = 1'b0;
    bus.cmd_valid_i = 1'b0; bus.cmd_op_i = 2'b00; bus.cmd_addr_i = '0;
    bus.cmd_data_i = '0; bus.cmd_mask_i = '0;
    m_edges = 0;
    #2 rst_n = 1'b0;
    #2;
    // Reset state
    check("rst_psel",    64'(bus.psel_o), 64'(0));
    check("rst_penable", 64'(bus.penable_o), 64'(0));
    check("rst_paddr",   64'(bus.paddr_o), 64'(0));
    check("rst_irq",     64'(irq_trigger_o), 64'(0));
    check("rst_rdvalid", 64'(rd_valid_o), 64'(0));
    check("rst_counts",  64'({irq_count_o, mismatch_cnt_o}), 64'(0));
    check("rst_errs",    64'({err_timeout_o, err_slverr_o}), 64'(0));
    check("rst_busy",    64'(busy_o), 64'(0));
    check("rst_ready",   64'(bus.cmd_ready_o), 64'(1));
    tick();
    rst_n = 1'b1;
    tick();

    // Zero-wait write, cycle by cycle
    resp_wait = 0;
    bus.cmd_op_i = 2'b00; bus.cmd_addr_i = 32'h2; bus.cmd_data_i = 32'hF; bus.cmd_valid_i = 1'b1;
    check("a_ready_idle", 64'(bus.cmd_ready_o), 64'(1));
    tick();
    bus.cmd_valid_i = 1'b0;
    check("a_setup_sel",  64'({bus.psel_o, bus.penable_o, busy_o, bus.cmd_ready_o}), 64'(4'b1010));
    check("a_setup_bus",  64'({bus.pwrite_o, bus.paddr_o, bus.pwdata_o}), 64'({1'b1, 32'h2, 32'hF}));
    tick();
    check("a_access_sel", 64'({bus.psel_o, bus.penable_o}), 64'(2'b11));
    tick();
    check("a_done_sel",   64'({bus.psel_o, bus.penable_o, busy_o, bus.cmd_ready_o}), 64'(4'b0001));
    check("a_done_err",   64'({err_timeout_o, err_slverr_o}), 64'(0));

    // Command table
    for (int i = 0; i < 12; i++) begin
      clear_stats();
      resp_wait = tbl[i].wt; resp_rdata = tbl[i].rdata; resp_err = tbl[i].slverr;
      run_cmd(tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].mask, cyc);
      check($sformatf("tbl%0d_cycles", i), 64'(cyc), 64'(tbl[i].e_cyc));
      check($sformatf("tbl%0d_psel", i),   64'(m_psel), 64'(tbl[i].e_psel));
      check($sformatf("tbl%0d_rdv", i),    64'(m_rdv), 64'(tbl[i].e_rdv));
      check($sformatf("tbl%0d_trig", i),   64'(m_trig), 64'(tbl[i].e_trig));
      if (tbl[i].e_trig > 0) check($sformatf("tbl%0d_trigval", i), 64'(m_trig_val), 64'(tbl[i].e_tv));
      if (tbl[i].e_rdv > 0)  check($sformatf("tbl%0d_rddata", i), 64'(rd_data_o), 64'(tbl[i].rdata));
      if (tbl[i].op[1] == 1'b0) begin
        check($sformatf("tbl%0d_paddr", i),  64'(m_addr), 64'(tbl[i].addr));
        check($sformatf("tbl%0d_pwdata", i), 64'(m_wdata), (tbl[i].op == 2'b00) ? 64'(tbl[i].data) : 64'(0));
        check($sformatf("tbl%0d_pwrite", i), 64'(m_pwrite), 64'(tbl[i].op == 2'b00));
      end
      check($sformatf("tbl%0d_mis", i),    64'(mismatch_cnt_o), 64'(tbl[i].e_mis));
      check($sformatf("tbl%0d_errto", i),  64'(err_timeout_o), 64'(tbl[i].e_to));
      check($sformatf("tbl%0d_errslv", i), 64'(err_slverr_o), 64'(tbl[i].e_slv));
      check($sformatf("tbl%0d_busy", i),   64'(busy_o), 64'(0));
      resp_err = 1'b0;
    end
    clear_stats();
    check("clr_errto", 64'(err_timeout_o), 64'(0));

    // Interrupt edge counting; clear wins over a coincident edge
    for (int k = 0; k < 3; k++) begin
      interrupt_i = 1'b1; tick(); tick();
      interrupt_i = 1'b0; tick(); tick();
    end
    check("irq_count_3", 64'(irq_count_o), 64'(3));
    interrupt_i = 1'b1; clr_stat_i = 1'b1;
    tick();
    clr_stat_i = 1'b0;
    tick(); tick();
    check("irq_clr_wins", 64'(irq_count_o), 64'(0));
    interrupt_i = 1'b0; tick();

    // enable_i=0 freezes a WAIT of 4 cycles
    bus.cmd_op_i = 2'b11; bus.cmd_data_i = 32'd4; bus.cmd_valid_i = 1'b1;
    tick();
    bus.cmd_valid_i = 1'b0; enable_i = 1'b0;
    repeat (3) tick();
    check("frz_busy",  64'(busy_o), 64'(1));
    check("frz_ready", 64'(bus.cmd_ready_o), 64'(0));
    enable_i = 1'b1;
    cyc = 0;
    while (!bus.cmd_ready_o && cyc < 50) begin
      tick();
      cyc++;
    end
    check("frz_remaining", 64'(cyc), 64'(4));

    // Saturation of both counters
    clear_stats();
    for (int k = 0; k < 260; k++) begin
      interrupt_i = 1'b1; tick();
      interrupt_i = 1'b0; tick();
    end
    check("irq_sat", 64'(irq_count_o), 64'(255));
    resp_wait = 0; resp_rdata = 32'h0;
    for (int k = 0; k < 256; k++) run_cmd(2'b01, 32'h8, 32'h1, 32'h1, cyc);
    check("mis_sat", 64'(mismatch_cnt_o), 64'(255));
    clear_stats();

    // Reset during ACCESS and during PULSE
    resp_wait = 1000;
    bus.cmd_op_i = 2'b01; bus.cmd_addr_i = 32'h40; bus.cmd_valid_i = 1'b1;
    tick();
    bus.cmd_valid_i = 1'b0;
    tick(); tick();
    check("c_in_access", 64'({bus.psel_o, bus.penable_o}), 64'(2'b11));
    #2 rst_n = 1'b0;
    #1;
    check("c_rst_sel",   64'({bus.psel_o, bus.penable_o}), 64'(0));
    check("c_rst_busy",  64'(busy_o), 64'(0));
    check("c_rst_ready", 64'(bus.cmd_ready_o), 64'(1));
    tick();
    rst_n = 1'b1;
    resp_wait = 0;
    bus.cmd_op_i = 2'b10; bus.cmd_data_i = 32'hF; bus.cmd_valid_i = 1'b1;
    tick();
    bus.cmd_valid_i = 1'b0;
    check("c_pulse_on", 64'(irq_trigger_o), 64'(4'hF));
    #2 rst_n = 1'b0;
    #1;
    check("c_rst_irq", 64'(irq_trigger_o), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();
    run_cmd(2'b00, 32'h2, 32'hF, 32'h0, cyc);
    check("c_after_cycles", 64'(cyc), 64'(3));
    check("c_after_psel",   64'(m_psel), 64'(2));
    check("c_after_errs",   64'({err_timeout_o, err_slverr_o}), 64'(0));

    // Randomized command stream with random interrupt_i activity
    clear_stats();
    mdl_mis = 0; mdl_to = 1'b0; mdl_slv = 1'b0; m_edges = 0;
    irq_rand = 1'b1;
    for (int n = 0; n < 150; n++) begin
      op    = 2'($urandom_range(0, 3));
      addr  = $urandom;
      data  = $urandom;
      mask  = $urandom;
      wt    = ($urandom_range(0, 7) == 0) ? 1000 : int'($urandom_range(0, 4));
      rdata = ($urandom_range(0, 1) == 1) ? data : $urandom;
      err   = ($urandom_range(0, 7) == 0);
      if (op == 2'b11) data = 32'($urandom_range(0, 6));
      resp_wait = wt; resp_rdata = rdata; resp_err = err;
      run_cmd(op, addr, data, mask, cyc);

      apb  = (op[1] == 1'b0);
      done = apb && (wt < int'(TO));
      if (apb)               exp_cyc = done ? wt + 3 : int'(TO) + 2;
      else if (op == 2'b10)  exp_cyc = int'(PW) + 1;
      else                   exp_cyc = ((data[15:0] == 16'd0) ? 1 : int'(data[15:0])) + 1;
      exp_rdv  = (done && op == 2'b01) ? 1 : 0;
      exp_trig = (op == 2'b10 && data[3:0] != 4'h0) ? int'(PW) : 0;
      if (apb && !done) mdl_to = 1'b1;
      if (done && err)  mdl_slv = 1'b1;
      if (exp_rdv == 1 && ((rdata ^ data) & mask) != 32'h0 && mdl_mis < 255) mdl_mis++;

      check($sformatf("rnd%0d_cycles", n), 64'(cyc), 64'(exp_cyc));
      check($sformatf("rnd%0d_rdv", n),    64'(m_rdv), 64'(exp_rdv));
      check($sformatf("rnd%0d_trig", n),   64'(m_trig), 64'(exp_trig));
      if (exp_rdv == 1) check($sformatf("rnd%0d_rddata", n), 64'(rd_data_o), 64'(rdata));
      check($sformatf("rnd%0d_mis", n),    64'(mismatch_cnt_o), 64'(mdl_mis));
      check($sformatf("rnd%0d_errto", n),  64'(err_timeout_o), 64'(mdl_to));
      check($sformatf("rnd%0d_errslv", n), 64'(err_slverr_o), 64'(mdl_slv));
    end
    irq_rand = 1'b0;
    interrupt_i = 1'b0;
    resp_err = 1'b0;
    tick(); tick(); tick();
    check("rnd_irq_count", 64'(irq_count_o), 64'((m_edges > 255) ? 255 : m_edges));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
